// File: rtl/ps2_command_tx.sv
// rtl/ps2_command_tx.sv - host-to-device PS/2 command byte transmitter (open-drain CLK/DAT)
// Optional watchdog: define PS2_TX_TIMEOUT_EN.
module ps2_command_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] command,
  input  logic       send,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DAT,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int MAX_CYC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAX_CYC + 1);
  // INHIBIT lasts one cycle less than INHIBIT_CYCLES; the REQ cycle completes the low time.
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 2);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_XFER, S_ACK, S_WAIT_IDLE, S_DONE
  } state_t;

  state_t state, state_n;

  logic [9:0]    sr;
  logic [3:0]    bit_cnt;
  logic [CW-1:0] cnt;
  logic          dat_low_q;
  logic          err_q;
  logic          clk_s1, clk_s, clk_q;
  logic          dat_s1, dat_s;
  logic          fall;
  logic          clk_low, dat_low;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_s1 <= 1'b1;
      clk_s  <= 1'b1;
      clk_q  <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s  <= 1'b1;
    end else begin
      clk_s1 <= PS2_CLK;
      clk_s  <= clk_s1;
      clk_q  <= clk_s;
      dat_s1 <= PS2_DAT;
      dat_s  <= dat_s1;
    end
  end

  assign fall = clk_q & ~clk_s;

`ifdef PS2_TX_TIMEOUT_EN
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic timeout;
  assign timeout = ((state == S_XFER) || (state == S_ACK) || (state == S_WAIT_IDLE))
                   && (cnt == TO_LAST);
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:      if (send) state_n = S_INHIBIT;
      S_INHIBIT:   if (cnt == INH_LAST) state_n = S_REQ;
      S_REQ:       state_n = S_XFER;
      S_XFER:      if (fall && bit_cnt == 4'd9) state_n = S_ACK;
      S_ACK:       if (fall) state_n = S_WAIT_IDLE;
      S_WAIT_IDLE: if (clk_s && dat_s) state_n = S_DONE;
      S_DONE:      state_n = S_IDLE;
      default:     state_n = S_IDLE;
    endcase
`ifdef PS2_TX_TIMEOUT_EN
    if (timeout) state_n = S_DONE;
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sr        <= 10'd0;
      bit_cnt   <= 4'd0;
      cnt       <= '0;
      dat_low_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (send) begin
            sr      <= {1'b1, ~^command, command};
            bit_cnt <= 4'd0;
            cnt     <= '0;
            err_q   <= 1'b0;
          end
        end
        S_INHIBIT: cnt <= cnt + 1'b1;
        S_REQ: begin
          cnt       <= '0;
          dat_low_q <= 1'b1;
        end
        S_XFER: begin
`ifdef PS2_TX_TIMEOUT_EN
          cnt <= cnt + 1'b1;
`endif
          if (fall) begin
            dat_low_q <= ~sr[bit_cnt];
            bit_cnt   <= bit_cnt + 4'd1;
          end
        end
        S_ACK: begin
`ifdef PS2_TX_TIMEOUT_EN
          cnt <= cnt + 1'b1;
`endif
          dat_low_q <= 1'b0;
          if (fall) err_q <= dat_s;
        end
        S_WAIT_IDLE: begin
`ifdef PS2_TX_TIMEOUT_EN
          cnt <= cnt + 1'b1;
`endif
        end
        default: ;
      endcase
`ifdef PS2_TX_TIMEOUT_EN
      if (timeout) begin
        err_q     <= 1'b1;
        dat_low_q <= 1'b0;
      end
`endif
    end
  end

  // Line drives decode straight from state so an asynchronous reset releases them at once.
  assign clk_low = (state == S_INHIBIT) || (state == S_REQ);
  assign dat_low = (state == S_REQ) || ((state == S_XFER) && dat_low_q);

  assign PS2_CLK = clk_low ? 1'b0 : 1'bz;
  assign PS2_DAT = dat_low ? 1'b0 : 1'bz;

  assign busy  = (state != S_IDLE) && (state != S_DONE);
  assign done  = (state == S_DONE);
  assign error = done & err_q;

endmodule
